// File: rtl/pmbus_monitor.sv
// Passive PMBus/I2C byte monitor: filters the master-side SCL/SDA, decodes START/STOP
// and bytes, and queues {address, from-slave, ack, data} records in a 4-deep show-ahead FIFO.
module pmbus_monitor #(
    parameter int DEBOUNCE = 5
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda,
    input  logic       sda_direction_tap,
    input  logic       rd_en,
    input  logic       clr_status,
    output logic       rec_valid,
    output logic [7:0] rec_data,
    output logic [2:0] rec_flags,
    output logic       busy,
    output logic       overflow,
    output logic       truncated
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic                scl_sync_p0, scl_sync_p1, sda_sync_p0, sda_sync_p1;
    logic [DEBOUNCE-1:0] scl_shift, sda_shift, scl_shift_next, sda_shift_next;
    logic                scl_filt, sda_filt, scl_prev, sda_prev;
    logic                scl_rise, sda_fall, sda_rise, start_evt, stop_evt;

    state_t              state, state_next;
    logic                shift_bit, push, trunc_evt;
    logic [3:0]          bit_cnt;
    logic                addr_flag, slave_flag;
    logic [7:0]          data_sr;

    logic [10:0]         mem [4];
    logic [1:0]          wr_ptr, rd_ptr;
    logic [2:0]          count;
    logic                pop, wr, ovf_evt;
    logic [10:0]         head;

    // The filtered level is updated from the shift register's next contents so the
    // decision lands on the same edge the last agreeing sample enters.
    assign scl_shift_next = {scl_shift[DEBOUNCE-2:0], scl_sync_p1};
    assign sda_shift_next = {sda_shift[DEBOUNCE-2:0], sda_sync_p1};

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            scl_sync_p0 <= 1'b1;
            scl_sync_p1 <= 1'b1;
            sda_sync_p0 <= 1'b1;
            sda_sync_p1 <= 1'b1;
            scl_shift   <= '1;
            sda_shift   <= '1;
            scl_filt    <= 1'b1;
            sda_filt    <= 1'b1;
            scl_prev    <= 1'b1;
            sda_prev    <= 1'b1;
        end else begin
            scl_sync_p0 <= scl;
            scl_sync_p1 <= scl_sync_p0;
            sda_sync_p0 <= sda;
            sda_sync_p1 <= sda_sync_p0;
            scl_shift   <= scl_shift_next;
            sda_shift   <= sda_shift_next;
            if (&scl_shift_next)      scl_filt <= 1'b1;
            else if (~|scl_shift_next) scl_filt <= 1'b0;
            if (&sda_shift_next)      sda_filt <= 1'b1;
            else if (~|sda_shift_next) sda_filt <= 1'b0;
            scl_prev    <= scl_filt;
            sda_prev    <= sda_filt;
        end
    end

    assign scl_rise  = scl_filt & ~scl_prev;
    assign sda_fall  = ~sda_filt & sda_prev;
    assign sda_rise  = sda_filt & ~sda_prev;
    assign start_evt = sda_fall & scl_filt & scl_prev;
    assign stop_evt  = sda_rise & scl_filt & scl_prev;

    // Bus decode
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        shift_bit  = 1'b0;
        push       = 1'b0;
        trunc_evt  = 1'b0;
        if (stop_evt) begin
            state_next = IDLE;
            trunc_evt  = (bit_cnt != 4'd0);
        end else if (start_evt) begin
            state_next = ACTIVE;
            trunc_evt  = (bit_cnt != 4'd0);
        end else if (state == ACTIVE && scl_rise) begin
            if (bit_cnt == 4'd8) push      = 1'b1;
            else                 shift_bit = 1'b1;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 4'd0;
            addr_flag <= 1'b0;
        end else if (start_evt) begin
            bit_cnt   <= 4'd0;
            addr_flag <= 1'b1;
        end else if (stop_evt) begin
            bit_cnt   <= 4'd0;
        end else if (shift_bit) begin
            bit_cnt   <= bit_cnt + 4'd1;
        end else if (push) begin
            bit_cnt   <= 4'd0;
            addr_flag <= 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (shift_bit) begin
            data_sr <= {data_sr[6:0], sda_filt};
            if (bit_cnt == 4'd0) slave_flag <= sda_direction_tap;
        end
    end

    assign busy = (state == ACTIVE);

    // Record FIFO
    assign pop     = rd_en && (count != 3'd0);
    assign wr      = push && ((count != 3'd4) || pop);
    assign ovf_evt = push && (count == 3'd4) && !pop;

    always_ff @(posedge sysclk) begin
        if (wr) mem[wr_ptr] <= {addr_flag, slave_flag, sda_filt, data_sr};
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            overflow  <= 1'b0;
            truncated <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            if (wr && !pop)      count <= count + 3'd1;
            else if (!wr && pop) count <= count - 3'd1;
            if (ovf_evt)         overflow  <= 1'b1;
            else if (clr_status) overflow  <= 1'b0;
            if (trunc_evt)       truncated <= 1'b1;
            else if (clr_status) truncated <= 1'b0;
        end
    end

    assign head      = mem[rd_ptr];
    assign rec_valid = (count != 3'd0);
    assign rec_data  = rec_valid ? head[7:0]  : 8'd0;
    assign rec_flags = rec_valid ? head[10:8] : 3'd0;

endmodule

// File: tb/tb_pmbus_monitor.sv
// Directed bench for pmbus_monitor: a table of byte transactions with expected records,
// followed by hand-written overflow, truncation, glitch and mid-transaction reset sequences.
module tb_pmbus_monitor;

    localparam int DEBOUNCE = 5;
    localparam int HOLD     = 12;

    logic       sysclk = 1'b0;
    logic       reset, scl, sda, tap, rd_en, clr_status;
    logic       rec_valid, busy, overflow, truncated;
    logic [7:0] rec_data;
    logic [2:0] rec_flags;

    int n_checks = 0;
    int n_fail   = 0;

    pmbus_monitor #(.DEBOUNCE(DEBOUNCE)) dut (
        .sysclk(sysclk), .reset(reset), .scl(scl), .sda(sda),
        .sda_direction_tap(tap), .rd_en(rd_en), .clr_status(clr_status),
        .rec_valid(rec_valid), .rec_data(rec_data), .rec_flags(rec_flags),
        .busy(busy), .overflow(overflow), .truncated(truncated)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic       start;
        logic [7:0] data;
        logic       tap;
        logic       ack;
        logic       stop;
        logic [2:0] flags;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic bus_start();
        sda = 1'b1; idle(HOLD);
        scl = 1'b1; idle(HOLD);
        sda = 1'b0; idle(HOLD);
        scl = 1'b0; idle(HOLD);
    endtask

    task automatic bus_stop();
        sda = 1'b0; idle(HOLD);
        scl = 1'b1; idle(HOLD);
        sda = 1'b1; idle(HOLD);
    endtask

    task automatic send_bit(input logic b);
        sda = b;    idle(HOLD);
        scl = 1'b1; idle(HOLD);
        scl = 1'b0; idle(HOLD);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7-i]);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic tp, input logic ack);
        tap = tp;
        send_bits(v, 8);
        tap = 1'b0;
        send_bit(ack);
    endtask

    task automatic pop_check(input string name, input logic [7:0] d, input logic [2:0] f);
        int k = 0;
        while (!rec_valid && k < 400) begin
            idle(1);
            k++;
        end
        check({name, " valid"}, 32'(rec_valid), 32'd1);
        check({name, " data"},  32'(rec_data),  32'(d));
        check({name, " flags"}, 32'(rec_flags), 32'(f));
        rd_en = 1'b1; idle(1);
        rd_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{start: 1'b1, data: 8'hB4, tap: 1'b0, ack: 1'b0, stop: 1'b0, flags: 3'b100};
        vecs[1] = '{start: 1'b0, data: 8'h03, tap: 1'b0, ack: 1'b0, stop: 1'b1, flags: 3'b000};
        vecs[2] = '{start: 1'b1, data: 8'hB5, tap: 1'b0, ack: 1'b0, stop: 1'b0, flags: 3'b100};
        vecs[3] = '{start: 1'b0, data: 8'h7E, tap: 1'b1, ack: 1'b1, stop: 1'b1, flags: 3'b011};
        vecs[4] = '{start: 1'b1, data: 8'hA0, tap: 1'b0, ack: 1'b1, stop: 1'b1, flags: 3'b101};
        vecs[5] = '{start: 1'b1, data: 8'h00, tap: 1'b0, ack: 1'b0, stop: 1'b0, flags: 3'b100};
        vecs[6] = '{start: 1'b0, data: 8'hFF, tap: 1'b1, ack: 1'b0, stop: 1'b1, flags: 3'b010};

        reset = 1'b1; scl = 1'b1; sda = 1'b1; tap = 1'b0; rd_en = 1'b0; clr_status = 1'b0;
        idle(3);
        check("reset rec_valid", 32'(rec_valid), 32'd0);
        check("reset rec_data",  32'(rec_data),  32'd0);
        check("reset rec_flags", 32'(rec_flags), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset overflow",  32'(overflow),  32'd0);
        check("reset truncated", 32'(truncated), 32'd0);
        reset = 1'b0;
        idle(HOLD);
        check("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].start) begin
                bus_start();
                check($sformatf("vec%0d busy after start", i), 32'(busy), 32'd1);
            end
            tap = vecs[i].tap;
            send_bits(vecs[i].data, 8);
            tap = 1'b0;
            sda = vecs[i].ack; idle(HOLD);
            scl = 1'b1;
            idle(DEBOUNCE + 2);
            check($sformatf("vec%0d valid before latency", i), 32'(rec_valid), 32'd0);
            idle(1);
            check($sformatf("vec%0d valid at latency", i), 32'(rec_valid), 32'd1);
            idle(HOLD - DEBOUNCE - 3);
            scl = 1'b0; idle(HOLD);
            pop_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].flags);
            check($sformatf("vec%0d drained", i), 32'(rec_valid), 32'd0);
            if (vecs[i].stop) begin
                bus_stop();
                check($sformatf("vec%0d busy after stop", i), 32'(busy), 32'd0);
            end
        end
        check("table overflow", 32'(overflow), 32'd0);

        // Six bytes with no reads: the first four survive.
        bus_start();
        send_byte(8'h10, 1'b0, 1'b0);
        send_byte(8'h21, 1'b0, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        send_byte(8'h43, 1'b0, 1'b0);
        check("full no overflow yet", 32'(overflow), 32'd0);
        send_byte(8'h54, 1'b0, 1'b0);
        send_byte(8'h65, 1'b0, 1'b0);
        bus_stop();
        check("overflow set", 32'(overflow), 32'd1);
        pop_check("ovf rec0", 8'h10, 3'b100);
        pop_check("ovf rec1", 8'h21, 3'b000);
        pop_check("ovf rec2", 8'h32, 3'b000);
        pop_check("ovf rec3", 8'h43, 3'b000);
        check("ovf drained", 32'(rec_valid), 32'd0);
        rd_en = 1'b1; idle(2);
        rd_en = 1'b0;
        check("empty read ignored", 32'(rec_valid), 32'd0);
        clr_status = 1'b1; idle(1);
        clr_status = 1'b0;
        check("overflow cleared", 32'(overflow), 32'd0);

        // Repeated START after a partial byte.
        bus_start();
        send_bits(8'hA0, 3);
        clr_status = 1'b1; idle(1);
        clr_status = 1'b0;
        check("trunc before rs", 32'(truncated), 32'd0);
        bus_start();
        check("trunc after rs", 32'(truncated), 32'd1);
        check("trunc no record", 32'(rec_valid), 32'd0);
        send_byte(8'h5A, 1'b0, 1'b0);
        pop_check("trunc next", 8'h5A, 3'b100);
        bus_stop();
        clr_status = 1'b1; idle(1);
        clr_status = 1'b0;
        check("trunc cleared", 32'(truncated), 32'd0);

        // Sub-DEBOUNCE glitches: a high pulse while low and a low pulse while high.
        bus_start();
        send_bits(8'hC2, 3);
        scl = 1'b1; idle(DEBOUNCE - 1);
        scl = 1'b0; idle(HOLD);
        sda = 1'b0; idle(HOLD);
        scl = 1'b1; idle(HOLD);
        scl = 1'b0; idle(DEBOUNCE - 1);
        scl = 1'b1; idle(HOLD);
        scl = 1'b0; idle(HOLD);
        send_bits(8'h20, 4);
        send_bit(1'b0);
        pop_check("glitch", 8'hC2, 3'b100);
        check("glitch single record", 32'(rec_valid), 32'd0);
        bus_stop();

        // Reset in the middle of a byte.
        bus_start();
        send_bits(8'hB8, 5);
        reset = 1'b1; idle(3);
        check("mid reset busy",  32'(busy),      32'd0);
        check("mid reset valid", 32'(rec_valid), 32'd0);
        reset = 1'b0;
        idle(HOLD);
        send_bits(8'h55, 8);
        send_bit(1'b0);
        check("post reset no record", 32'(rec_valid), 32'd0);
        check("post reset busy",      32'(busy),      32'd0);
        bus_start();
        send_byte(8'h3C, 1'b0, 1'b0);
        pop_check("post reset rec", 8'h3C, 3'b100);
        bus_stop();
        check("post reset final busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pmbus_monitor.md
PMBUS_MONITOR -- requirements
Module: pmbus_monitor

Interface
REQ-001 Parameter DEBOUNCE, default 5: number of consecutive equal samples required before a filtered SCL/SDA level changes.
REQ-002 sysclk  input  1  system clock; all logic is synchronous to its rising edge except the asynchronous reset.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 scl  input  1  raw bus SCL on the master side of the PMBus pass-through.
REQ-005 sda  input  1  raw bus SDA on the master side of the PMBus pass-through.
REQ-006 sda_direction_tap  input  1  pass-through direction; 1 = slave driving SDA, 0 = master driving SDA.
REQ-007 rd_en  input  1  pops the FIFO head when rec_valid=1.
REQ-008 clr_status  input  1  clears overflow and truncated when high for one cycle.
REQ-009 rec_valid  output  1  FIFO not empty.
REQ-010 rec_data  output  8  FIFO head data byte, MSB first as seen on the bus.
REQ-011 rec_flags  output  3  FIFO head flags: [2] = address byte (first byte after START or repeated START); [1] = byte was driven by the slave; [0] = sampled ninth (ACK) bit, where 0 = ACK.
REQ-012 busy  output  1  1 while the monitor is between START and STOP.
REQ-013 overflow  output  1  sticky flag; a record was dropped because the FIFO was full.
REQ-014 truncated  output  1  sticky flag; a START or STOP arrived with a partial byte (1 to 8 bits) captured.

Function
REQ-015 scl and sda SHALL each pass through a 2-flop synchronizer and then a DEBOUNCE-deep shift register; the filtered level changes only when all DEBOUNCE samples are equal, and otherwise holds.
REQ-016 Edge detection SHALL compare the filtered value against its value on the previous cycle; edges are single-cycle events.
REQ-017 START: filtered SDA falls while filtered SCL is high on both the current and the previous cycle. STOP: filtered SDA rises under the same SCL condition.
REQ-018 FSM states: IDLE and ACTIVE. START in IDLE -> ACTIVE. STOP in any state -> IDLE. START in ACTIVE is a repeated START and stays ACTIVE. SCL edges in IDLE are ignored.
REQ-019 On every START: clear the bit counter to 0 and set the address-byte flag for the next record.
REQ-020 In ACTIVE, on each filtered SCL rising edge with bit counter 0-7: shift filtered SDA into the data register (MSB first) and increment the counter.
REQ-021 The from-slave flag SHALL be sampled from sda_direction_tap on the rising edge where the counter is 0.
REQ-022 On the rising edge where the counter is 8: sample the ACK bit, push {flags, data} into the FIFO in that same cycle, clear the counter to 0, and clear the address-byte flag.
REQ-023 START or STOP with counter 1-8 SHALL discard the partial byte, push nothing, and set truncated.
REQ-024 The FIFO SHALL hold 4 entries of 11 bits and be show-ahead: rec_data/rec_flags present the head whenever rec_valid=1.
REQ-025 rec_valid SHALL assert on the cycle after the push; end-to-end latency from a stable raw SCL rising edge of the ACK bit is DEBOUNCE+3 sysclk cycles.
REQ-026 A push while the FIFO is full SHALL drop the record and set overflow; a simultaneous push and pop while full SHALL both succeed and leave count=4.
REQ-027 rd_en while empty SHALL be ignored, and the pointers SHALL not move.
REQ-028 FIFO pointers are 2 bits and wrap modulo 4; a 3-bit count distinguishes full from empty.
REQ-029 clr_status in the same cycle as a new overflow or truncation event SHALL leave the flag set (set wins).

Reset
REQ-030 Reset SHALL force: filtered levels and synchronizers = 1; shift registers all 1; FSM = IDLE; counter = 0; FIFO empty; rec_valid = 0; rec_data = 0; rec_flags = 0; busy = 0; overflow = 0; truncated = 0.
REQ-031 Reset asserted mid-transaction SHALL discard all state; after release, decode resumes only at the next START.

Verification
REQ-032 Write to address 0x5A with byte 0x03, both ACKed, then STOP -> records {0xB4, flags 100} then {0x03, flags 000}; busy returns to 0.
REQ-033 Read from address 0x5A (tap=1 during data), data byte 0x7E, master NACK -> records {0xB5, 100} then {0x7E, 011}.
REQ-034 Six bytes pushed with no rd_en -> 4 records retained (the first 4), overflow=1; clr_status -> overflow=0.
REQ-035 Repeated START after 3 bits of a byte -> truncated=1, no record for the partial byte, next record has flag[2]=1.
REQ-036 Glitch on SCL of DEBOUNCE-1 cycles mid-byte -> no bit is captured and the record is unchanged.
REQ-037 Reset pulse after 5 bits of a byte -> FIFO empty, busy=0; SCL edges before the next START produce no records.
